// File: rtl/s2_kes_ctrl.sv
// Stage-2 scheduler between the syndrome stage and the t=2 BM key-equation solver.
// It buffers syndrome sets, launches one solver run at a time, and bypasses all-zero sets.
module s2_kes_ctrl #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned KES_LAT  = 5,
  parameter int unsigned WD_SLACK = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             syn_valid,
  output logic             syn_ready,
  input  logic [7:0]       syn0,
  input  logic [7:0]       syn1,
  input  logic [7:0]       syn2,
  input  logic [7:0]       syn3,
  output logic             kes_ena,
  output logic [7:0]       kes_syn0,
  output logic [7:0]       kes_syn1,
  output logic [7:0]       kes_syn2,
  output logic [7:0]       kes_syn3,
  input  logic             kes_done,
  input  logic [7:0]       kes_lambda0,
  input  logic [7:0]       kes_lambda1,
  input  logic [7:0]       kes_lambda2,
  input  logic [7:0]       kes_omega0,
  input  logic [7:0]       kes_omega1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_lambda0,
  output logic [7:0]       out_lambda1,
  output logic [7:0]       out_lambda2,
  output logic [7:0]       out_omega0,
  output logic [7:0]       out_omega1,
  output logic             out_err_free,
  output logic [TAG_W-1:0] out_tag,
  output logic             kes_timeout
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned WD_LIMIT = KES_LAT + WD_SLACK;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

  state_t             state, state_n;
  logic [31:0]        mem_syn [DEPTH];
  logic [TAG_W-1:0]   mem_tag [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [TAG_W-1:0]   tag_cnt;
  logic [TAG_W-1:0]   fl_tag;
  logic [WD_W-1:0]    wd;
  logic               full, empty, push, pop;
  logic [31:0]        head_syn;
  logic [TAG_W-1:0]   head_tag;
  logic               head_zero, slot_free;
  logic               launch_load, load_bypass, load_kes, timeout_set;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign syn_ready = !full;
  assign push      = syn_valid && !full;
  assign head_syn  = mem_syn[rd_ptr[AW-1:0]];
  assign head_tag  = mem_tag[rd_ptr[AW-1:0]];
  assign head_zero = (head_syn == '0);
  assign slot_free = !out_valid || out_ready;
  assign kes_ena   = (state == S_LAUNCH);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_syn[wr_ptr[AW-1:0]] <= {syn0, syn1, syn2, syn3};
      mem_tag[wr_ptr[AW-1:0]] <= tag_cnt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + (AW+1)'(1);
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    launch_load = 1'b0;
    load_bypass = 1'b0;
    load_kes    = 1'b0;
    timeout_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (head_zero) begin
            if (slot_free) begin
              pop         = 1'b1;
              load_bypass = 1'b1;
            end
          end else begin
            pop         = 1'b1;
            launch_load = 1'b1;
            state_n     = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_n = S_WAIT;
      S_WAIT: begin
        if (kes_done) begin
          if (slot_free) begin
            load_kes = 1'b1;
            state_n  = S_IDLE;
          end else begin
            state_n = S_HOLD;
          end
        end else if (wd == WD_W'(WD_LIMIT - 1)) begin
          timeout_set = 1'b1;
          state_n     = S_IDLE;
        end
      end
      S_HOLD: begin
        if (slot_free) begin
          load_kes = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // wd counts cycles since the launch pulse; firing on WD_LIMIT-1 makes
  // kes_timeout visible exactly WD_LIMIT cycles after kes_ena.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      wd          <= '0;
      kes_timeout <= 1'b0;
      fl_tag      <= '0;
      kes_syn0    <= '0;
      kes_syn1    <= '0;
      kes_syn2    <= '0;
      kes_syn3    <= '0;
    end else begin
      state <= state_n;
      if (launch_load) begin
        kes_syn0 <= head_syn[31:24];
        kes_syn1 <= head_syn[23:16];
        kes_syn2 <= head_syn[15:8];
        kes_syn3 <= head_syn[7:0];
        fl_tag   <= head_tag;
      end
      if (state == S_LAUNCH)    wd <= WD_W'(1);
      else if (state == S_WAIT) wd <= wd + WD_W'(1);
      if (timeout_set) kes_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      out_lambda0  <= '0;
      out_lambda1  <= '0;
      out_lambda2  <= '0;
      out_omega0   <= '0;
      out_omega1   <= '0;
      out_err_free <= 1'b0;
      out_tag      <= '0;
    end else if (load_bypass) begin
      out_valid    <= 1'b1;
      out_lambda0  <= 8'h01;
      out_lambda1  <= '0;
      out_lambda2  <= '0;
      out_omega0   <= '0;
      out_omega1   <= '0;
      out_err_free <= 1'b1;
      out_tag      <= head_tag;
    end else if (load_kes) begin
      out_valid    <= 1'b1;
      out_lambda0  <= kes_lambda0;
      out_lambda1  <= kes_lambda1;
      out_lambda2  <= kes_lambda2;
      out_omega0   <= kes_omega0;
      out_omega1   <= kes_omega1;
      out_err_free <= 1'b0;
      out_tag      <= fl_tag;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s2_kes_ctrl.sv
// Self-checking bench for s2_kes_ctrl: directed scenarios plus a randomized phase,
// with a queue-based model of codeword order, solver responses and the watchdog.
module tb_s2_kes_ctrl;

  localparam int KES_LAT  = 5;
  localparam int WD_SLACK = 2;

  logic       clk, rstn;
  logic       syn_valid, syn_ready;
  logic [7:0] syn0, syn1, syn2, syn3;
  logic       kes_ena;
  logic [7:0] kes_syn0, kes_syn1, kes_syn2, kes_syn3;
  logic       kes_done;
  logic [7:0] kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1;
  logic       out_valid, out_ready;
  logic [7:0] out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1;
  logic       out_err_free;
  logic [3:0] out_tag;
  logic       kes_timeout;

  s2_kes_ctrl #(.DEPTH(2), .TAG_W(4), .KES_LAT(KES_LAT), .WD_SLACK(WD_SLACK)) dut (
    .clk(clk), .rstn(rstn),
    .syn_valid(syn_valid), .syn_ready(syn_ready),
    .syn0(syn0), .syn1(syn1), .syn2(syn2), .syn3(syn3),
    .kes_ena(kes_ena),
    .kes_syn0(kes_syn0), .kes_syn1(kes_syn1), .kes_syn2(kes_syn2), .kes_syn3(kes_syn3),
    .kes_done(kes_done),
    .kes_lambda0(kes_lambda0), .kes_lambda1(kes_lambda1), .kes_lambda2(kes_lambda2),
    .kes_omega0(kes_omega0), .kes_omega1(kes_omega1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lambda0(out_lambda0), .out_lambda1(out_lambda1), .out_lambda2(out_lambda2),
    .out_omega0(out_omega0), .out_omega1(out_omega1),
    .out_err_free(out_err_free), .out_tag(out_tag),
    .kes_timeout(kes_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [31:0] syn;
    logic [3:0]  tag;
    bit          zero;
    bit          launched;
    bit          resolved;
    logic [39:0] res;
  } ent_t;

  ent_t       order[$];
  logic [3:0] got[$];
  logic [3:0] mtag;
  int         nid, cyc, n_ena, lat, fl_lat, fl_id, fl_cyc;
  bit         inflight, model_to, fix_en;
  int         npass, ntotal;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  function automatic int find_id(input int id);
    for (int i = 0; i < order.size(); i++)
      if (order[i].id == id) return i;
    return -1;
  endfunction

  task automatic model_reset();
    order.delete();
    mtag = 4'd0;
    inflight = 1'b0;
    model_to = 1'b0;
  endtask

  task automatic check_take();
    chk("out_pending", order.size() > 0, 1);
    if (order.size() > 0) begin
      chk("out_resolved", order[0].resolved, 1);
      chk("out_tag", out_tag, order[0].tag);
      chk("out_err_free", out_err_free, order[0].zero);
      chk("out_result", {out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1}, order[0].res);
      got.push_back(out_tag);
      void'(order.pop_front());
    end
  endtask

  task automatic on_launch();
    int idx;
    idx = -1;
    chk("one_run_at_a_time", inflight, 0);
    for (int i = 0; i < order.size(); i++)
      if (idx < 0 && !order[i].zero && !order[i].launched) idx = i;
    chk("launch_has_target", idx >= 0, 1);
    n_ena++;
    if (idx >= 0) begin
      chk("kes_syn", {kes_syn0, kes_syn1, kes_syn2, kes_syn3}, order[idx].syn);
      order[idx].launched = 1'b1;
      fl_id    = order[idx].id;
      fl_cyc   = cyc;
      fl_lat   = lat;
      inflight = 1'b1;
    end
  endtask

  task automatic answer();
    int idx;
    logic [39:0] r;
    r = fix_en ? 40'h01_0A_0B_0C_0D : {$urandom(), 8'($urandom())};
    kes_done = 1'b1;
    {kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1} = r;
    idx = find_id(fl_id);
    if (idx >= 0) begin
      order[idx].res      = r;
      order[idx].resolved = 1'b1;
    end
    inflight = 1'b0;
  endtask

  // One clock: account handshakes of the ending cycle, then model the new one.
  task automatic step();
    bit   push_f, take_f;
    ent_t e;
    int   idx;
    push_f = syn_valid && syn_ready;
    take_f = out_valid && out_ready;
    if (take_f) check_take();
    if (push_f) begin
      e.id       = nid++;
      e.syn      = {syn0, syn1, syn2, syn3};
      e.tag      = mtag;
      mtag       = mtag + 4'd1;
      e.zero     = (e.syn == 32'd0);
      e.launched = 1'b0;
      e.resolved = e.zero;
      e.res      = 40'h01_00_00_00_00;
      order.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    kes_done = 1'b0;
    if (kes_ena) on_launch();
    if (inflight && fl_lat != 0 && cyc == fl_cyc + fl_lat) answer();
    if (inflight && cyc == fl_cyc + KES_LAT + WD_SLACK) begin
      model_to = 1'b1;
      idx = find_id(fl_id);
      if (idx >= 0) order.delete(idx);
      inflight = 1'b0;
    end
    chk("kes_timeout", kes_timeout, model_to);
  endtask

  task automatic push_set(input logic [31:0] s);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    syn_valid = 1'b1;
    {syn0, syn1, syn2, syn3} = s;
    while (!acc && n < 200) begin
      acc = syn_ready;
      step();
      n++;
    end
    syn_valid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (order.size() > 0 && n < max) begin
      step();
      n++;
    end
    chk("drain_empty", order.size(), 0);
  endtask

  initial begin
    int c, e0, n0;
    logic [3:0] t;
    npass = 0; ntotal = 0; nid = 0; cyc = 0; n_ena = 0; lat = KES_LAT; fix_en = 1'b0;
    fl_lat = 0; fl_id = -1; fl_cyc = 0;
    model_reset();
    rstn = 1'b1; syn_valid = 1'b0; out_ready = 1'b0; kes_done = 1'b0;
    {syn0, syn1, syn2, syn3} = '0;
    {kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1} = '0;
    #2 rstn = 1'b0;
    #10;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_kes_ena", kes_ena, 0);
    chk("rst_timeout", kes_timeout, 0);
    chk("rst_out_bus", {out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1, out_err_free, out_tag}, 0);
    chk("rst_kes_syn", {kes_syn0, kes_syn1, kes_syn2, kes_syn3}, 0);
    rstn = 1'b1;
    #1;
    chk("rst_syn_ready", syn_ready, 1);

    // Single non-zero codeword with the fixed solver answer.
    out_ready = 1'b1;
    fix_en = 1'b1;
    push_set(32'h12_34_56_78);
    chk("t1_no_ena_at_pop", kes_ena, 0);
    step();
    chk("t1_ena", kes_ena, 1);
    chk("t1_kes_syn", {kes_syn0, kes_syn1, kes_syn2, kes_syn3}, 32'h12_34_56_78);
    c = cyc;
    repeat (5) step();
    chk("t1_done_cycle", kes_done, 1);
    chk("t1_not_yet_valid", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_latency", cyc - c, 6);
    chk("t1_result", {out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1}, 40'h01_0A_0B_0C_0D);
    chk("t1_tag", out_tag, 0);
    chk("t1_err_free", out_err_free, 0);
    fix_en = 1'b0;
    step();

    // All-zero set bypasses the solver.
    e0 = n_ena;
    push_set(32'h0);
    chk("t2_not_yet_valid", out_valid, 0);
    step();
    chk("t2_out_valid", out_valid, 1);
    chk("t2_err_free", out_err_free, 1);
    chk("t2_result", {out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1}, 40'h01_00_00_00_00);
    chk("t2_no_launch", n_ena - e0, 0);
    drain(20);

    // Non-zero then zero back-to-back must leave in tag order.
    n0 = got.size();
    push_set(32'hA1_B2_C3_D4);
    push_set(32'h0);
    drain(40);
    chk("t3_count", got.size() - n0, 2);
    t = got[n0] + 4'd1;
    chk("t3_order", got[n0 + 1], t);

    // Slot blocked across kes_done: HOLD, no further launch.
    out_ready = 1'b0;
    push_set(32'h0);
    e0 = n_ena;
    push_set(32'h11_22_33_44);
    push_set(32'h55_66_77_88);
    repeat (20) step();
    chk("t4_single_launch", n_ena - e0, 1);
    chk("t4_slot_held", out_valid, 1);
    chk("t4_held_tag", out_tag, order[0].tag);
    drain(60);

    // FIFO fills while the first codeword is in the solver.
    push_set(32'h01_02_03_04);
    step();
    chk("t5_launch", kes_ena, 1);
    push_set(32'h05_06_07_08);
    push_set(32'h09_0A_0B_0C);
    chk("t5_full", syn_ready, 0);
    push_set(32'h0D_0E_0F_10);
    drain(80);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      syn_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) {syn0, syn1, syn2, syn3} = '0;
      else {syn0, syn1, syn2, syn3} = $urandom();
      out_ready = ($urandom_range(0, 9) < 7);
      lat = $urandom_range(1, KES_LAT + WD_SLACK - 1);
      step();
    end
    syn_valid = 1'b0;
    lat = KES_LAT;
    drain(200);

    // Solver never answers: watchdog, then normal recovery.
    lat = 0;
    push_set(32'hDE_AD_BE_EF);
    step();
    chk("t6_launch", kes_ena, 1);
    c = cyc;
    repeat (KES_LAT + WD_SLACK - 1) step();
    chk("t6_no_timeout_yet", kes_timeout, 0);
    step();
    chk("t6_timeout", kes_timeout, 1);
    chk("t6_timeout_cycle", cyc - c, KES_LAT + WD_SLACK);
    lat = KES_LAT;
    n0 = got.size();
    push_set(32'hCA_FE_F0_0D);
    drain(40);
    chk("t6_recovered", got.size() - n0, 1);

    // Reset in the middle of a solver run.
    out_ready = 1'b0;
    push_set(32'h0);
    push_set(32'h31_41_59_26);
    step();
    step();
    chk("t7_slot_before_rst", out_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t7_rst_out_valid", out_valid, 0);
    chk("t7_rst_kes_ena", kes_ena, 0);
    chk("t7_rst_timeout", kes_timeout, 0);
    model_reset();
    step();
    #3 rstn = 1'b1;
    step();
    chk("t7_syn_ready", syn_ready, 1);
    out_ready = 1'b1;
    n0 = got.size();
    push_set(32'h0);
    drain(20);
    chk("t7_tag_restart", got.size() > n0 ? got[n0] : 4'hF, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
